// File: rtl/flop_pkg.sv
// ============================================================================
// Module      : flop_pkg
// Description : Shared widths, field positions and FSM encoding for flop_argmax.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package flop_pkg;

    localparam int c_EXP_W_DEF  = 4;
    localparam int c_MANT_W_DEF = 8;
    localparam int c_IDX_W_DEF  = 8;

    // Sample layout is {sign, mant, exp} with the exponent in the LSBs.
    localparam int c_EXP_LSB  = 0;
    localparam int c_MANT_LSB = c_EXP_W_DEF;
    localparam int c_SIGN_POS = c_EXP_W_DEF + c_MANT_W_DEF;

    localparam int         c_ST_W    = 2;
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ACC  = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

endpackage : flop_pkg

`default_nettype wire

// File: rtl/flop_cmp.sv
// ============================================================================
// Module      : flop_cmp
// Description : Combinational strict greater-than for {sign, mant, exp} samples.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module flop_cmp
    import flop_pkg::*;
#(
    parameter int EXP_W  = c_EXP_W_DEF,
    parameter int MANT_W = c_MANT_W_DEF
) (
    input  logic [EXP_W+MANT_W:0] i_a,
    input  logic [EXP_W+MANT_W:0] i_b,
    output logic                  a_gt_b
);

    localparam int c_SIGN = EXP_W + MANT_W;

    logic [c_SIGN-1:0] w_key_a;
    logic [c_SIGN-1:0] w_key_b;

    assign w_key_a = {i_a[EXP_W-1:0], i_a[c_SIGN-1:EXP_W]};
    assign w_key_b = {i_b[EXP_W-1:0], i_b[c_SIGN-1:EXP_W]};

    // sign=1 marks non-negative values; among negatives a smaller key is larger.
    always_comb begin
        if (i_a[c_SIGN] != i_b[c_SIGN]) begin
            a_gt_b = i_a[c_SIGN];
        end else if (i_a[c_SIGN]) begin
            a_gt_b = (w_key_a > w_key_b);
        end else begin
            a_gt_b = (w_key_a < w_key_b);
        end
    end

endmodule : flop_cmp

`default_nettype wire

// File: rtl/flop_argmax.sv
// ============================================================================
// Module      : flop_argmax
// Description : Per-frame max (and optional min, FLOP_ARGMAX_MIN_EN) with index.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module flop_argmax
    import flop_pkg::*;
#(
    parameter int EXP_W  = c_EXP_W_DEF,
    parameter int MANT_W = c_MANT_W_DEF,
    parameter int IDX_W  = c_IDX_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MANT_W+EXP_W:0]     in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MANT_W+EXP_W:0]     out_max,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      out_ovf
`ifdef FLOP_ARGMAX_MIN_EN
    ,
    output logic [MANT_W+EXP_W:0]     out_min,
    output logic [IDX_W-1:0]          out_min_idx
`endif
);

    localparam int W = 1 + MANT_W + EXP_W;

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_nxt;
    logic              w_acc;
    logic              w_first;

    logic [W-1:0]      r_max;
    logic [W-1:0]      w_max_nxt;
    logic [W-1:0]      r_out_max;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [IDX_W-1:0]  r_out_idx;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_ovf;
    logic              w_gt_max;

    assign w_acc   = in_valid && in_ready;
    assign w_first = (r_state == c_ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_acc) w_state_nxt = in_last ? c_ST_HOLD : c_ST_ACC;
            c_ST_ACC:  if (w_acc && in_last) w_state_nxt = c_ST_HOLD;
            c_ST_HOLD: if (out_ready) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state != c_ST_HOLD);
        out_valid = (r_state == c_ST_HOLD);
    end

    flop_cmp #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_cmp_max (
        .i_a    (in_data),
        .i_b    (r_max),
        .a_gt_b (w_gt_max)
    );

    // The first sample of a frame loads unconditionally; later ones replace only when strictly greater.
    always_comb begin
        w_max_nxt = r_max;
        w_idx_nxt = r_idx;
        if (w_first || w_gt_max) begin
            w_max_nxt = in_data;
            w_idx_nxt = w_first ? '0 : r_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_max     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_max <= '0;
            r_out_idx <= '0;
        end else begin
            if (w_acc) begin
                r_max <= w_max_nxt;
                r_idx <= w_idx_nxt;
                r_cnt <= w_first ? IDX_W'(1) : r_cnt + 1'b1;
                // In ACC the counter only reads zero once it has wrapped past 2^IDX_W samples.
                if (!w_first && (r_cnt == '0)) begin
                    r_ovf <= 1'b1;
                end
                if (in_last) begin
                    r_out_max <= w_max_nxt;
                    r_out_idx <= w_idx_nxt;
                end
            end
            if ((r_state == c_ST_HOLD) && out_ready) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign out_max = r_out_max;
    assign out_idx = r_out_idx;
    assign out_ovf = r_ovf;

`ifdef FLOP_ARGMAX_MIN_EN
    logic [W-1:0]     r_min;
    logic [W-1:0]     w_min_nxt;
    logic [W-1:0]     r_out_min;
    logic [IDX_W-1:0] r_min_idx;
    logic [IDX_W-1:0] w_min_idx_nxt;
    logic [IDX_W-1:0] r_out_min_idx;
    logic             w_lt_min;

    flop_cmp #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_cmp_min (
        .i_a    (r_min),
        .i_b    (in_data),
        .a_gt_b (w_lt_min)
    );

    always_comb begin
        w_min_nxt     = r_min;
        w_min_idx_nxt = r_min_idx;
        if (w_first || w_lt_min) begin
            w_min_nxt     = in_data;
            w_min_idx_nxt = w_first ? '0 : r_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_min         <= '0;
            r_min_idx     <= '0;
            r_out_min     <= '0;
            r_out_min_idx <= '0;
        end else if (w_acc) begin
            r_min     <= w_min_nxt;
            r_min_idx <= w_min_idx_nxt;
            if (in_last) begin
                r_out_min     <= w_min_nxt;
                r_out_min_idx <= w_min_idx_nxt;
            end
        end
    end

    assign out_min     = r_out_min;
    assign out_min_idx = r_out_min_idx;
`endif

endmodule : flop_argmax

`default_nettype wire
